// File: rtl/sp_frame_feeder.sv
// sp_frame_feeder: collects 9-sample frames into two ping-pong slots and issues them to an SP core.
// Define SP_FEEDER_TIMEOUT_EN to add a watchdog on result collection (timeout_err otherwise tied 0).
module sp_frame_feeder (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [8:0] s_data,
  input  logic [2:0] s_mode,
  output logic       sp_in_valid,
  output logic [8:0] sp_in_data,
  output logic [2:0] sp_in_mode,
  input  logic       sp_out_valid,
  output logic [7:0] frames_done,
  output logic       timeout_err
);

  // state    | meaning
  // IDLE     | no frame in flight; leave as soon as a slot is full
  // ISSUE    | 9 back-to-back beats from the oldest slot on sp_in_*
  // WAIT_RES | counting sp_out_valid beats; 3 beats complete the frame
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES} state_t;

  state_t     state, state_nxt;
  logic [8:0] slot_data [2][9];
  logic [2:0] slot_mode [2];
  logic [1:0] slot_full;
  logic       wr_slot, rd_slot;
  logic [3:0] fill_idx;
  logic [3:0] beat_idx, beat_idx_nxt;
  logic [1:0] res_cnt, res_cnt_nxt;
  logic       accept, fill_done, slot_free, frame_inc;
  logic       out_valid_nxt;
  logic [8:0] out_data_nxt;
  logic [2:0] out_mode_nxt;

`ifdef SP_FEEDER_TIMEOUT_EN
  logic [7:0] wdog;
  logic       timeout_hit;
`endif

  assign s_ready   = ~(slot_full[0] & slot_full[1]);
  assign accept    = s_valid & s_ready;
  assign fill_done = accept && (fill_idx == 4'd8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_idx <= 4'd0;
      wr_slot  <= 1'b0;
    end else if (accept) begin
      if (fill_idx == 4'd8) begin
        fill_idx <= 4'd0;
        wr_slot  <= ~wr_slot;
      end else begin
        fill_idx <= fill_idx + 4'd1;
      end
    end
  end

  // Sample storage needs no reset: a slot is only read after its full flag is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      slot_data[wr_slot][fill_idx] <= s_data;
      if (fill_idx == 4'd0) slot_mode[wr_slot] <= s_mode;
    end
  end

  // Free and fill always target different slots, so both may land on one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_full <= 2'b00;
      rd_slot   <= 1'b0;
    end else begin
      if (slot_free) begin
        slot_full[rd_slot] <= 1'b0;
        rd_slot            <= ~rd_slot;
      end
      if (fill_done) slot_full[wr_slot] <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    beat_idx_nxt  = beat_idx;
    res_cnt_nxt   = res_cnt;
    out_valid_nxt = 1'b0;
    out_data_nxt  = 9'd0;
    out_mode_nxt  = 3'd0;
    slot_free     = 1'b0;
    frame_inc     = 1'b0;
`ifdef SP_FEEDER_TIMEOUT_EN
    timeout_hit   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|slot_full) begin
          state_nxt     = ISSUE;
          beat_idx_nxt  = 4'd0;
          out_valid_nxt = 1'b1;
          out_data_nxt  = slot_data[rd_slot][0];
          out_mode_nxt  = slot_mode[rd_slot];
        end
      end
      ISSUE: begin
        // The slot is released as beat 8 is consumed, i.e. on leaving ISSUE.
        if (beat_idx == 4'd8) begin
          state_nxt   = WAIT_RES;
          res_cnt_nxt = 2'd0;
          slot_free   = 1'b1;
        end else begin
          beat_idx_nxt  = beat_idx + 4'd1;
          out_valid_nxt = 1'b1;
          out_data_nxt  = slot_data[rd_slot][beat_idx + 4'd1];
        end
      end
      WAIT_RES: begin
        if (sp_out_valid && res_cnt == 2'd2) begin
          state_nxt   = IDLE;
          res_cnt_nxt = 2'd0;
          frame_inc   = 1'b1;
        end else begin
          if (sp_out_valid) res_cnt_nxt = res_cnt + 2'd1;
`ifdef SP_FEEDER_TIMEOUT_EN
          if (wdog == 8'd0) begin
            state_nxt   = IDLE;
            res_cnt_nxt = 2'd0;
            timeout_hit = 1'b1;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      beat_idx    <= 4'd0;
      res_cnt     <= 2'd0;
      frames_done <= 8'd0;
      sp_in_valid <= 1'b0;
      sp_in_data  <= 9'd0;
      sp_in_mode  <= 3'd0;
    end else begin
      state       <= state_nxt;
      beat_idx    <= beat_idx_nxt;
      res_cnt     <= res_cnt_nxt;
      sp_in_valid <= out_valid_nxt;
      sp_in_data  <= out_data_nxt;
      sp_in_mode  <= out_mode_nxt;
      if (frame_inc) frames_done <= frames_done + 8'd1;
    end
  end

`ifdef SP_FEEDER_TIMEOUT_EN
  // Down-counter reloaded outside WAIT_RES; terminal count on the 200th WAIT_RES cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog        <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (state != WAIT_RES) wdog <= 8'd199;
      else if (wdog != 8'd0) wdog <= wdog - 8'd1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule
